skew_delay_bank: RTL and testbench
==================================

# skew_delay_bank

Parametrised multi-channel delay line that skews (or de-skews) a vector of operands across CHANNELS lanes, carrying a per-lane valid bit and a done strobe alongside the data. It sits between the operand buffers and the systolic array edge. Each lane gets a different fixed latency, so operands enter successive PE rows/columns one cycle apart. It generalises the single-bit done-delay register to arbitrary width, depth and lane count, and adds stall, flush and occupancy tracking.

## Interface
Parameters:
- WIDTH, 8, data bits per lane
- CHANNELS, 4, number of lanes (≥1)
- BASE_DELAY, 1, latency of the shortest lane in cycles (≥1)
- SKEW_DIR, 0, 0 = lane c delayed BASE_DELAY+c (skew); 1 = lane c delayed BASE_DELAY+(CHANNELS-1-c) (de-skew)

Ports:
- clk  input  1  single clock, all registers update on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  advance enable; low = whole bank holds
- flush  input  1  discard all in-flight entries
- in_valid  input  1  input vector valid (common to all lanes)
- in_data  input  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
- done_in  input  1  end-of-stream strobe, qualified by en
- out_valid  output  CHANNELS  per-lane valid
- out_data  output  CHANNELS*WIDTH  per-lane delayed data, same packing as in_data
- done_out  output  1  delayed done strobe
- busy  output  1  any valid or done bit in flight

## Operation
- Lane delay D(c) as set by SKEW_DIR. DMAX = BASE_DELAY+CHANNELS-1. Lane c is a D(c)-stage shift register of {valid, data}.
- Done pipe: a DMAX-stage 1-bit shift register. done_out asserts in the same cycle as the final valid of the longest lane for the vector that accompanied done_in.
- Priority per edge: rst > flush > en > hold.
  - rst: all valid bits, done bits and data stages cleared to 0.
  - flush: all valid bits and done bits cleared. Data stages keep their contents. in_valid/done_in presented that cycle are dropped. Applies regardless of en.
  - en=1: every stage shifts one place. Stage 0 loads {in_valid, in_data lane} and done_in.
  - en=0: every stage holds. in_valid/done_in are ignored; the upstream block must not present new data while en is low.
- A cycle with in_valid=0 and en=1 inserts a bubble (valid 0). The lane data is still captured.
- out_data lane c = last-stage data when out_valid[c]=1, else 0 (masked).
- busy = OR of every valid stage bit and every done stage bit. Purely a function of registers.
- No combinational path from any input to any output.

## Timing
- Reset values: out_valid=0, out_data=0, done_out=0, busy=0, from the cycle after rst is sampled high.
- Latency with en held high: a vector accepted at edge k appears on lane c after edge k+D(c)−1 completes, i.e. visible during cycle k+D(c).
- Each accepted vector appears exactly once per lane, for one enabled cycle. Back-to-back input gives back-to-back output, with throughput 1 vector per cycle.
- Each en=0 cycle adds exactly one cycle to the latency of every in-flight entry. While en=0, outputs are frozen.
- flush: out_valid, done_out and busy read 0 in the cycle after the flush edge. A vector accepted on the next edge sees the normal latency.
- rst mid-stream: identical effect to flush, and additionally zeroes the data stages.
- CHANNELS=1: single lane of BASE_DELAY. done_out is aligned to that lane.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, done_in=1 → out_valid=0000, out_data=0, done_out=0, busy=0 throughout and one cycle after release.
- Skew, WIDTH=8, CHANNELS=4, BASE_DELAY=2, SKEW_DIR=0: in_data lanes 0..3 = 0x11,0x22,0x33,0x44 accepted at cycle 0 → lane0 0x11 valid at cycle 2, lane1 0x22 at 3, lane2 0x33 at 4, lane3 0x44 at 5. Each is valid for exactly one cycle; busy falls at cycle 6.
- Stream with done: 8 consecutive vectors (lane value = 8·idx+c) at cycles 0–7, done_in with the last → lane3 outputs at cycles 5–12 in order, done_out high only at cycle 12.
- Stall: same stream with en=0 for cycles 3–5 (no input offered) → all outputs frozen during the stall. Every later output shifts by +3 cycles, done_out lands at cycle 15, and no entry is duplicated or lost.
- Flush: assert flush at cycle 4 of the stream, together with in_valid=1 → out_valid=0000, busy=0, done_out=0 at cycle 5. The vector at cycle 4 never appears. A new vector at cycle 6 reaches lane0 at cycle 8.
- De-skew, SKEW_DIR=1, same parameters: single vector at cycle 0 → lane3 at cycle 2, lane2 at 3, lane1 at 4, lane0 at 5. A done_in sent with it gives done_out at cycle 5.

Source files
------------

// File: rtl/skew_delay_bank.sv
// Multi-lane delay bank: lane c carries {valid, data} through a fixed-depth shift register
// so that operands reach successive array edges one cycle apart, plus an aligned done strobe.
module skew_delay_bank #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int BASE_DELAY = 1,
    parameter int SKEW_DIR   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      done_in,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      done_out,
    output logic                      busy
);
    localparam int DMAX = BASE_DELAY + CHANNELS - 1;

    function automatic int lane_delay(input int c);
        if (SKEW_DIR == 0) begin
            return BASE_DELAY + c;
        end else begin
            return BASE_DELAY + (CHANNELS - 1 - c);
        end
    endfunction

    logic [CHANNELS-1:0] lane_busy_s;
    logic [DMAX-1:0]     done_r;
    logic [DMAX-1:0]     done_chain_s;

    for (genvar s = 0; s < DMAX; s++) begin : g_done_chain
        if (s == 0) begin : g_head
            assign done_chain_s[s] = done_in;
        end else begin : g_body
            assign done_chain_s[s] = done_r[s-1];
        end
    end

    // Done strobe pipe, as deep as the longest lane so it lands with that lane's final valid
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= {DMAX{1'b0}};
        end else if (flush) begin
            done_r <= {DMAX{1'b0}};
        end else if (en) begin
            done_r <= done_chain_s;
        end else begin
            done_r <= done_r;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int D = lane_delay(c);

        logic [D-1:0]     vld_r;
        logic [D-1:0]     vld_chain_s;
        logic [WIDTH-1:0] dat_r       [D];
        logic [WIDTH-1:0] dat_chain_s [D];

        for (genvar s = 0; s < D; s++) begin : g_chain
            if (s == 0) begin : g_head
                assign vld_chain_s[s] = in_valid;
                assign dat_chain_s[s] = in_data[c*WIDTH +: WIDTH];
            end else begin : g_body
                assign vld_chain_s[s] = vld_r[s-1];
                assign dat_chain_s[s] = dat_r[s-1];
            end
        end

        // Lane valid bits: cleared by reset and flush, shifted when enabled
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= {D{1'b0}};
            end else if (flush) begin
                vld_r <= {D{1'b0}};
            end else if (en) begin
                vld_r <= vld_chain_s;
            end else begin
                vld_r <= vld_r;
            end
        end

        // Lane data stages: flush leaves them alone since the cleared valids already hide them
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < D; i++) begin
                    dat_r[i] <= {WIDTH{1'b0}};
                end
            end else if (en && !flush) begin
                for (int i = 0; i < D; i++) begin
                    dat_r[i] <= dat_chain_s[i];
                end
            end else begin
                for (int i = 0; i < D; i++) begin
                    dat_r[i] <= dat_r[i];
                end
            end
        end

        assign out_valid[c]                 = vld_r[D-1];
        assign out_data[c*WIDTH +: WIDTH]   = vld_r[D-1] ? dat_r[D-1] : {WIDTH{1'b0}};
        assign lane_busy_s[c]               = |vld_r;
    end

    assign done_out = done_r[DMAX-1];
    assign busy     = (|lane_busy_s) | (|done_r);

endmodule

// File: tb/tb_skew_delay_bank.sv
// Scoreboard bench for skew_delay_bank: a skewing and a de-skewing instance share one stimulus
// stream; each accepted vector is queued per lane with the enabled-cycle count at which it must show.
module tb_skew_delay_bank;
    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid, done_in;
    logic [31:0] in_data;
    logic [3:0]  sk_valid, dk_valid;
    logic [31:0] sk_data, dk_data;
    logic        sk_done, dk_done, sk_busy, dk_busy;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int qdue [8][$];
    int qdat [8][$];
    int dq   [2][$];

    always #5 clk = ~clk;

    skew_delay_bank #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(2), .SKEW_DIR(0)) u_skew (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .done_in(done_in), .out_valid(sk_valid),
        .out_data(sk_data), .done_out(sk_done), .busy(sk_busy)
    );

    skew_delay_bank #(.WIDTH(8), .CHANNELS(4), .BASE_DELAY(2), .SKEW_DIR(1)) u_deskew (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .done_in(done_in), .out_valid(dk_valid),
        .out_data(dk_data), .done_out(dk_done), .busy(dk_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dly(input int i, input int c);
        return 2 + ((i == 0) ? c : 3 - c);
    endfunction

    function automatic logic [31:0] vec(input int base, input int idx);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) begin
            r[c*8 +: 8] = 8'(base + 8*idx + c);
        end
        return r;
    endfunction

    task automatic compare_inst(input int i, input logic [3:0] v, input logic [31:0] d,
                                input logic dn, input logic b);
        logic [3:0]  ev;
        logic [31:0] ed;
        logic        edn;
        logic        eb;
        int          val;
        string       nm;
        ev  = 4'b0;
        ed  = 32'b0;
        eb  = 1'b0;
        edn = 1'b0;
        nm  = (i == 0) ? "skew" : "deskew";
        for (int c = 0; c < 4; c++) begin
            if (qdue[i*4+c].size() > 0) begin
                eb = 1'b1;
                if (qdue[i*4+c][0] == en_cnt) begin
                    val           = qdat[i*4+c][0];
                    ev[c]         = 1'b1;
                    ed[c*8 +: 8]  = val[7:0];
                end
            end
        end
        if (dq[i].size() > 0) begin
            eb  = 1'b1;
            edn = (dq[i][0] == en_cnt);
        end
        check_val($sformatf("%s.valid", nm), {28'b0, v}, {28'b0, ev});
        check_val($sformatf("%s.data", nm), d, ed);
        check_val($sformatf("%s.done", nm), {31'b0, dn}, {31'b0, edn});
        check_val($sformatf("%s.busy", nm), {31'b0, b}, {31'b0, eb});
    endtask

    // One clock: check what is visible now, then drive the next edge and update the scoreboard
    task automatic cycle(input logic r, input logic e, input logic f, input logic v,
                         input logic dn, input logic [31:0] d);
        @(negedge clk);
        compare_inst(0, sk_valid, sk_data, sk_done, sk_busy);
        compare_inst(1, dk_valid, dk_data, dk_done, dk_busy);
        rst = r; en = e; flush = f; in_valid = v; done_in = dn; in_data = d;
        if (r || f) begin
            for (int k = 0; k < 8; k++) begin
                qdue[k].delete();
                qdat[k].delete();
            end
            dq[0].delete();
            dq[1].delete();
        end else if (e) begin
            for (int k = 0; k < 8; k++) begin
                if (qdue[k].size() > 0 && qdue[k][0] == en_cnt) begin
                    void'(qdue[k].pop_front());
                    void'(qdat[k].pop_front());
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (dq[i].size() > 0 && dq[i][0] == en_cnt) void'(dq[i].pop_front());
            end
            en_cnt++;
            if (v) begin
                for (int i = 0; i < 2; i++) begin
                    for (int c = 0; c < 4; c++) begin
                        qdue[i*4+c].push_back(en_cnt + dly(i, c) - 1);
                        qdat[i*4+c].push_back(int'(d[c*8 +: 8]));
                    end
                end
            end
            if (dn) begin
                dq[0].push_back(en_cnt + 4);
                dq[1].push_back(en_cnt + 4);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; done_in = 1'b0; in_data = 32'h0;

        // reset held two cycles with live input
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        idle(1);

        // single vector with done
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4433_2211);
        idle(7);

        // back-to-back stream, done with the last vector
        for (int t = 0; t < 8; t++) cycle(1'b0, 1'b1, 1'b0, 1'b1, (t == 7), vec(0, t));
        idle(10);

        // same stream with a three-cycle stall
        for (int t = 0; t < 11; t++) begin
            if (t >= 3 && t <= 5) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            end else begin
                int idx;
                idx = (t < 3) ? t : t - 3;
                cycle(1'b0, 1'b1, 1'b0, 1'b1, (idx == 7), vec(64, idx));
            end
        end
        idle(14);

        // flush at cycle 4 with a vector offered, new vector at cycle 6
        for (int t = 0; t < 4; t++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, vec(128, t));
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, vec(128, 4));
        idle(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, vec(128, 6));
        idle(8);

        // flush while stalled
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, vec(16, 0));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, vec(16, 1));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(6);

        // reset mid-stream
        for (int t = 0; t < 3; t++) cycle(1'b0, 1'b1, 1'b0, 1'b1, (t == 1), vec(200, t));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, vec(200, 3));
        idle(7);

        // random traffic
        for (int t = 0; t < 80; t++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), $urandom);
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
